// File: rtl/ones_comp_pkg.sv
// Shared constants for the bit-serial ones'-complement subtractor:
// FSM state encoding and the supported operand width range.
package ones_comp_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS1 = 2'd1;
    localparam logic [1:0] ST_PASS2 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ones_comp_serial_sub_full_adder.sv
// Single-bit full adder cell; the serial subtractor time-shares one instance.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Cout
);

    assign Y    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/ones_comp_serial_sub.sv
// Bit-serial ones'-complement subtractor Y = A - B: pass 1 forms A + ~B LSB first,
// pass 2 folds the end-around carry back in, then the result is offered on a valid/ready port.
module ones_comp_serial_sub
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] Y,
    output logic             neg_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             accept;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] nb_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic             a_msb;
    logic             b_msb;

    logic [WIDTH-1:0] y_reg;
    logic             neg_zero_reg;
    logic             overflow_reg;
    logic             resp_valid_reg;

    logic             fa_a;
    logic             fa_b;
    logic             fa_sum;
    logic             fa_cout;

    assign req_ready  = (state == ST_IDLE);
    assign accept     = req_valid & req_ready;
    assign last_bit   = (bit_cnt == CW'(WIDTH - 1));

    assign resp_valid = resp_valid_reg;
    assign Y          = y_reg;
    assign neg_zero   = neg_zero_reg;
    assign overflow   = overflow_reg;

    // Pass 2 re-circulates the partial sum with a zero addend so only the carry ripples in.
    assign fa_a = (state == ST_PASS2) ? s_sr[0]  : a_sr[0];
    assign fa_b = (state == ST_PASS1) ? nb_sr[0] : 1'b0;

    full_adder u_fa (
        .A    (fa_a),
        .B    (fa_b),
        .Cin  (carry),
        .Y    (fa_sum),
        .Cout (fa_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)                      state_nxt = ST_PASS1;
            ST_PASS1: if (last_bit)                    state_nxt = ST_PASS2;
            ST_PASS2: if (last_bit)                    state_nxt = ST_DONE;
            ST_DONE:  if (resp_valid_reg && resp_ready) state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr    <= '0;
            nb_sr   <= '0;
            s_sr    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_sr    <= A;
                        nb_sr   <= ~B;
                        s_sr    <= '0;
                        carry   <= 1'b0;
                        bit_cnt <= '0;
                        a_msb   <= A[WIDTH-1];
                        b_msb   <= B[WIDTH-1];
                    end
                end
                ST_PASS1: begin
                    a_sr    <= a_sr >> 1;
                    nb_sr   <= nb_sr >> 1;
                    s_sr    <= {fa_sum, s_sr[WIDTH-1:1]};
                    carry   <= fa_cout;
                    bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
                end
                ST_PASS2: begin
                    s_sr    <= {fa_sum, s_sr[WIDTH-1:1]};
                    // The carry out of the end-around add is always zero, so it is dropped.
                    carry   <= last_bit ? 1'b0 : fa_cout;
                    bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // The output stage loads in the first DONE cycle and then holds until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_reg          <= '0;
            neg_zero_reg   <= 1'b0;
            overflow_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
        end else if (state == ST_DONE) begin
            if (!resp_valid_reg) begin
                y_reg          <= s_sr;
                neg_zero_reg   <= &s_sr;
                overflow_reg   <= (a_msb != b_msb) && (s_sr[WIDTH-1] != a_msb);
                resp_valid_reg <= 1'b1;
            end else if (resp_ready) begin
                resp_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ones_comp_serial_sub.sv
// Scoreboard bench for ones_comp_serial_sub: accepts are captured into an expected queue,
// a monitor checks every presented response against an arithmetic ones'-complement model.
module tb_ones_comp_serial_sub;

    localparam int W       = 4;
    localparam int LATENCY = 2 * W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] y_out;
    logic         neg_zero;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_hs_edge = -100;
    bit seen_resp = 1'b0;

    typedef struct {
        logic [W-1:0] y;
        logic         nz;
        logic         ov;
        int           acc_edge;
    } exp_t;

    exp_t sb[$];

    ones_comp_serial_sub #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .A          (a_in),
        .B          (b_in),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .Y          (y_out),
        .neg_zero   (neg_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ones'-complement difference: add the bitwise complement, then fold any carry back in.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int edge_idx);
        exp_t e;
        int   sum;
        sum = int'(a) + ((1 << W) - 1 - int'(b));
        if (sum >= (1 << W)) sum = sum - (1 << W) + 1;
        e.y        = W'(sum);
        e.nz       = (sum == (1 << W) - 1);
        e.ov       = (a[W-1] != b[W-1]) && (e.y[W-1] != a[W-1]);
        e.acc_edge = edge_idx;
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor runs on the falling edge, so it sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_resp", {31'd0, resp_valid}, 32'd0);
                end else begin
                    if (!seen_resp) begin
                        check_output("latency", 32'(cyc - sb[0].acc_edge), 32'(LATENCY));
                        seen_resp = 1'b1;
                    end
                    check_output("Y", {28'd0, y_out}, {28'd0, sb[0].y});
                    check_output("neg_zero", {31'd0, neg_zero}, {31'd0, sb[0].nz});
                    check_output("overflow", {31'd0, overflow}, {31'd0, sb[0].ov});
                    check_output("req_ready_done", {31'd0, req_ready}, 32'd0);
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        seen_resp    = 1'b0;
                        last_hs_edge = cyc + 1;
                    end
                end
            end
            if (req_valid && req_ready) begin
                sb.push_back(model(a_in, b_in, cyc + 1));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check_output({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check_output({tag, "_Y"}, {28'd0, y_out}, 32'd0);
        check_output({tag, "_neg_zero"}, {31'd0, neg_zero}, 32'd0);
        check_output({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    task automatic wait_accept();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready && t < 60);
        if (!req_ready) check_output("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp_done();
        int t;
        t = 0;
        while (!resp_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!resp_valid) check_output("resp_timeout", 32'd0, 32'd1);
        t = 0;
        while (resp_valid && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (resp_valid) check_output("handshake_timeout", 32'd1, 32'd0);
    endtask

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int t;
        @(posedge clk);
        #1;
        a_in       = a;
        b_in       = b;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        wait_accept();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        a_in      = W'($urandom);
        b_in      = W'($urandom);
        if (hold > 0) begin
            t = 0;
            while (!resp_valid && t < 60) begin
                @(negedge clk);
                t++;
            end
            if (!resp_valid) check_output("resp_timeout_hold", 32'd0, 32'd1);
            repeat (hold) begin
                @(posedge clk);
                #1;
                check_output("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
                check_output("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
            resp_ready = 1'b1;
        end
        wait_resp_done();
    endtask

    task automatic reset_during_pass2(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        a_in       = a;
        b_in       = b;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (W + 2) @(posedge clk);
        #2;
        check_output("busy_before_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check_reset_values("midop_reset");
        sb.delete();
        seen_resp = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2 * W + 4) @(posedge clk);
        #1;
        check_output("no_resp_after_reset", {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic back_to_back(input logic [W-1:0] a1, input logic [W-1:0] b1,
                                input logic [W-1:0] a2, input logic [W-1:0] b2);
        @(posedge clk);
        #1;
        a_in       = a1;
        b_in       = b1;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        a_in = a2;
        b_in = b2;
        wait_accept();
        check_output("b2b_accept_edge", 32'(cyc + 1), 32'(last_hs_edge + 1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp_done();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        a_in       = '0;
        b_in       = '0;
        #1;
        check_reset_values("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        apply_stimulus(4'b0101, 4'b0011, 0);
        apply_stimulus(4'b0011, 4'b0101, 0);
        apply_stimulus(4'b0111, 4'b0111, 0);
        apply_stimulus(4'b0000, 4'b1111, 0);
        apply_stimulus(4'b0111, 4'b1000, 5);
        apply_stimulus(4'b1111, 4'b0000, 2);

        reset_during_pass2(4'b0110, 4'b0001);
        apply_stimulus(4'b0110, 4'b0001, 0);

        back_to_back(4'b0101, 4'b0011, 4'b1000, 4'b0111);

        for (int i = 0; i < 40; i++) begin
            apply_stimulus(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1;
        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
